// File: rtl/path_scheduler_if.sv
// Signal bundle between path_scheduler and its neighbours: the radar tracker,
// path_math and the rover transmitter. master = scheduler side, slave = environment side.
interface path_scheduler_if;
  logic        start;
  logic [11:0] target;
  logic [11:0] location;
  logic        location_valid;

  logic [11:0] math_location;
  logic [11:0] math_target;
  logic [4:0]  math_orientation;
  logic        math_enable;
  logic        math_done;
  logic [4:0]  math_needed_orientation;
  logic [11:0] math_move_command;

  logic        tx_start;
  logic [11:0] tx_command;
  logic        tx_done;

  logic [4:0]  current_orientation;
  logic [2:0]  step_count;
  logic        busy;
  logic        done;
  logic        arrived;
  logic        timeout_err;

  modport master (
    input  start, target, location, location_valid,
           math_done, math_needed_orientation, math_move_command, tx_done,
    output math_location, math_target, math_orientation, math_enable,
           tx_start, tx_command,
           current_orientation, step_count, busy, done, arrived, timeout_err
  );

  modport slave (
    output start, target, location, location_valid,
           math_done, math_needed_orientation, math_move_command, tx_done,
    input  math_location, math_target, math_orientation, math_enable,
           tx_start, tx_command,
           current_orientation, step_count, busy, done, arrived, timeout_err
  );
endinterface

// File: rtl/path_scheduler.sv
// Closed-loop move sequencer: waits for a radar fix, runs path_math, checks
// arrival, sends the move to the rover and tracks orientation until done.
//
// state        | meaning
// S_IDLE       | waiting for start after reset
// S_WAIT_LOC   | waiting for a fresh radar location
// S_MATH_START | pulse math_enable
// S_MATH_GUARD | skip one cycle, math_done may still be stale-high
// S_MATH_WAIT  | waiting for path_math to finish
// S_CHECK      | decide arrival / step exhaustion / move
// S_TX_START   | pulse tx_start
// S_TX_WAIT    | waiting for the transmitter to finish
// S_DONE       | run ended without error, flags held
// S_ERROR      | a wait state timed out, flags held
module path_scheduler #(
  parameter logic [6:0]  ARRIVE_DIST = 7'd8,
  parameter logic [2:0]  MAX_STEPS   = 3'd4,
  parameter logic [4:0]  INIT_ORIENT = 5'd6,
  parameter logic [24:0] TIMEOUT     = 25'd27_000_000
) (
  input  logic              i_clock,
  input  logic              i_reset,
  path_scheduler_if.master  io_sched
);

  typedef enum logic [3:0] {
    S_IDLE,
    S_WAIT_LOC,
    S_MATH_START,
    S_MATH_GUARD,
    S_MATH_WAIT,
    S_CHECK,
    S_TX_START,
    S_TX_WAIT,
    S_DONE,
    S_ERROR
  } state_t;

  state_t      r_state;
  state_t      w_state_next;

  logic [24:0] r_timer;
  logic [11:0] r_math_location;
  logic [11:0] r_math_target;
  logic [4:0]  r_needed_orient;
  logic [11:0] r_tx_command;
  logic [4:0]  r_orient;
  logic [2:0]  r_step_count;
  logic        r_arrived;
  logic        r_timeout_err;
  logic        r_done;

  logic        w_idle_like;
  logic        w_start_ok;
  logic        w_timer_tc;
  logic        w_arrive;

  assign w_idle_like = (r_state == S_IDLE) || (r_state == S_DONE) || (r_state == S_ERROR);
  assign w_start_ok  = w_idle_like && io_sched.start;
  assign w_timer_tc  = (r_timer == 25'd0);
  assign w_arrive    = (r_tx_command[6:0] <= ARRIVE_DIST);

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // In every wait state the awaited event is tested before the timer, so an
  // event landing on the terminal-count cycle still wins.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE, S_DONE, S_ERROR: begin
        if (io_sched.start) w_state_next = S_WAIT_LOC;
      end
      S_WAIT_LOC: begin
        if (io_sched.location_valid) w_state_next = S_MATH_START;
        else if (w_timer_tc)         w_state_next = S_ERROR;
      end
      S_MATH_START: w_state_next = S_MATH_GUARD;
      S_MATH_GUARD: w_state_next = S_MATH_WAIT;
      S_MATH_WAIT: begin
        if (io_sched.math_done) w_state_next = S_CHECK;
        else if (w_timer_tc)    w_state_next = S_ERROR;
      end
      S_CHECK: begin
        if (w_arrive)                         w_state_next = S_DONE;
        else if (r_step_count == MAX_STEPS)   w_state_next = S_DONE;
        else                                  w_state_next = S_TX_START;
      end
      S_TX_START: w_state_next = S_TX_WAIT;
      S_TX_WAIT: begin
        if (io_sched.tx_done) w_state_next = S_WAIT_LOC;
        else if (w_timer_tc)  w_state_next = S_ERROR;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // Down-counter reloaded on every state change; terminal count is zero, which
  // lands on the TIMEOUT-th cycle spent in a wait state.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_timer <= TIMEOUT - 25'd1;
    end else if (w_state_next != r_state) begin
      r_timer <= TIMEOUT - 25'd1;
    end else if (!w_timer_tc) begin
      r_timer <= r_timer - 25'd1;
    end
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_math_location <= 12'd0;
      r_math_target   <= 12'd0;
      r_needed_orient <= 5'd0;
      r_tx_command    <= 12'd0;
      r_orient        <= INIT_ORIENT;
      r_step_count    <= 3'd0;
      r_arrived       <= 1'b0;
      r_timeout_err   <= 1'b0;
      r_done          <= 1'b0;
    end else begin
      r_done <= (r_state == S_CHECK) && (w_state_next == S_DONE);

      if (w_start_ok) begin
        r_math_target <= io_sched.target;
        r_orient      <= INIT_ORIENT;
        r_step_count  <= 3'd0;
        r_arrived     <= 1'b0;
        r_timeout_err <= 1'b0;
      end

      if ((r_state == S_WAIT_LOC) && io_sched.location_valid) begin
        r_math_location <= io_sched.location;
      end

      if ((r_state == S_MATH_WAIT) && io_sched.math_done) begin
        r_needed_orient <= io_sched.math_needed_orientation;
        r_tx_command    <= io_sched.math_move_command;
      end

      if ((r_state == S_CHECK) && w_arrive) begin
        r_arrived <= 1'b1;
      end

      if ((r_state == S_TX_WAIT) && io_sched.tx_done) begin
        r_orient <= r_needed_orient;
        if (r_step_count != 3'd7) r_step_count <= r_step_count + 3'd1;
      end

      if ((w_state_next == S_ERROR) && (r_state != S_ERROR)) begin
        r_timeout_err <= 1'b1;
      end
    end
  end

  always_comb begin
    io_sched.math_enable         = (r_state == S_MATH_START);
    io_sched.tx_start            = (r_state == S_TX_START);
    io_sched.busy                = !w_idle_like;
    io_sched.done                = r_done;
    io_sched.arrived             = r_arrived;
    io_sched.timeout_err         = r_timeout_err;
    io_sched.math_location       = r_math_location;
    io_sched.math_target         = r_math_target;
    io_sched.math_orientation    = r_orient;
    io_sched.current_orientation = r_orient;
    io_sched.tx_command          = r_tx_command;
    io_sched.step_count          = r_step_count;
  end

endmodule

// File: tb/tb_path_scheduler.sv
// Directed bench for path_scheduler: arrival, step exhaustion, timeout,
// stale math_done and mid-run reset, with hand-computed expectations.
module tb_path_scheduler;

  logic clk;
  logic rst;
  int   n_pass;
  int   n_total;
  int   cnt_en;
  int   cnt_tx;
  int   cnt_done;
  int   snap_en;
  int   snap_tx;
  int   snap_done;

  path_scheduler_if u_bus ();

  path_scheduler #(
    .ARRIVE_DIST (7'd8),
    .MAX_STEPS   (3'd4),
    .INIT_ORIENT (5'd6),
    .TIMEOUT     (25'd100)
  ) u_dut (
    .i_clock  (clk),
    .i_reset  (rst),
    .io_sched (u_bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (u_bus.math_enable === 1'b1) cnt_en   <= cnt_en + 1;
    if (u_bus.tx_start === 1'b1)    cnt_tx   <= cnt_tx + 1;
    if (u_bus.done === 1'b1)        cnt_done <= cnt_done + 1;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  initial begin
    n_pass = 0; n_total = 0;
    cnt_en = 0; cnt_tx = 0; cnt_done = 0;
    rst = 1'b1;
    u_bus.start = 1'b0;
    u_bus.target = 12'h000;
    u_bus.location = 12'h000;
    u_bus.location_valid = 1'b0;
    u_bus.math_done = 1'b0;
    u_bus.math_needed_orientation = 5'd0;
    u_bus.math_move_command = 12'h000;
    u_bus.tx_done = 1'b0;
    step(); step();
    rst = 1'b0;
    step();

    // reset state
    chk("rst_busy",   u_bus.busy, 0);
    chk("rst_orient", u_bus.current_orientation, 6);
    chk("rst_steps",  u_bus.step_count, 0);
    chk("rst_en",     u_bus.math_enable, 0);
    chk("rst_tx",     u_bus.tx_start, 0);
    chk("rst_done",   u_bus.done, 0);
    chk("rst_arr",    u_bus.arrived, 0);
    chk("rst_terr",   u_bus.timeout_err, 0);

    // run 1, iteration 1: one move with distance 37
    u_bus.start = 1'b1; u_bus.target = 12'h850;
    step();
    u_bus.start = 1'b0;
    chk("r1_busy", u_bus.busy, 1);
    chk("r1_tgt",  u_bus.math_target, 12'h850);
    u_bus.location = 12'h140; u_bus.location_valid = 1'b1;
    step();
    u_bus.location_valid = 1'b0;
    chk("r1_en",     u_bus.math_enable, 1);
    chk("r1_loc",    u_bus.math_location, 12'h140);
    chk("r1_morient", u_bus.math_orientation, 6);
    step();
    chk("r1_en_off", u_bus.math_enable, 0);
    step();
    u_bus.math_done = 1'b1; u_bus.math_needed_orientation = 5'd9; u_bus.math_move_command = 12'h1A5;
    step();
    chk("r1_check_notx", u_bus.tx_start, 0);
    step();
    chk("r1_tx",    u_bus.tx_start, 1);
    chk("r1_txcmd", u_bus.tx_command, 12'h1A5);
    step();
    chk("r1_tx_off", u_bus.tx_start, 0);
    u_bus.tx_done = 1'b1;
    step();
    u_bus.tx_done = 1'b0;
    chk("r1_orient", u_bus.current_orientation, 9);
    chk("r1_steps",  u_bus.step_count, 1);
    chk("r1_busy2",  u_bus.busy, 1);
    chk("r1_en_cnt", cnt_en, 1);
    chk("r1_tx_cnt", cnt_tx, 1);

    // iteration 2: math_done stale-high through MATH_GUARD, then distance 5 arrives
    u_bus.location = 12'h150; u_bus.location_valid = 1'b1;
    step();
    u_bus.location_valid = 1'b0;
    chk("r2_morient", u_bus.math_orientation, 9);
    step();
    step();
    u_bus.math_done = 1'b0;
    step();
    chk("r2_guard_notx", u_bus.tx_start, 0);
    step();
    chk("r2_guard_busy", u_bus.busy, 1);
    chk("r2_guard_cmd",  u_bus.tx_command, 12'h1A5);
    u_bus.math_done = 1'b1; u_bus.math_needed_orientation = 5'd10; u_bus.math_move_command = 12'h505;
    step();
    step();
    chk("r2_done",  u_bus.done, 1);
    chk("r2_arr",   u_bus.arrived, 1);
    chk("r2_busy",  u_bus.busy, 0);
    chk("r2_notx",  cnt_tx, 1);
    chk("r2_orient", u_bus.current_orientation, 9);
    step();
    chk("r2_done_off", u_bus.done, 0);
    chk("r2_arr_hold", u_bus.arrived, 1);
    chk("r2_done_cnt", cnt_done, 1);

    // run 2: distance always 40, stops after MAX_STEPS moves; same-cycle location ignored
    snap_en = cnt_en; snap_tx = cnt_tx;
    u_bus.start = 1'b1; u_bus.target = 12'h3C0;
    u_bus.location = 12'h0AA; u_bus.location_valid = 1'b1;
    step();
    u_bus.start = 1'b0; u_bus.location_valid = 1'b0;
    chk("m_arr_clr", u_bus.arrived, 0);
    chk("m_orient",  u_bus.current_orientation, 6);
    chk("m_loc_ign", u_bus.math_location, 12'h150);
    for (int i = 0; i < 5; i++) begin
      u_bus.location = 12'h100 + 12'(i); u_bus.location_valid = 1'b1;
      step();
      u_bus.location_valid = 1'b0; u_bus.math_done = 1'b0;
      step(); step();
      u_bus.math_done = 1'b1;
      u_bus.math_needed_orientation = 5'(i + 1);
      u_bus.math_move_command = {5'(i + 1), 7'd40};
      step(); step();
      if (i < 4) begin
        chk("m_tx", u_bus.tx_start, 1);
        step();
        u_bus.tx_done = 1'b1;
        step();
        u_bus.tx_done = 1'b0;
        chk("m_steps",  u_bus.step_count, i + 1);
        chk("m_orient", u_bus.current_orientation, i + 1);
      end else begin
        chk("m_done",    u_bus.done, 1);
        chk("m_arr",     u_bus.arrived, 0);
        chk("m_steps_f", u_bus.step_count, 4);
        chk("m_notx",    u_bus.tx_start, 0);
      end
    end
    chk("m_tx_cnt", cnt_tx - snap_tx, 4);
    chk("m_en_cnt", cnt_en - snap_en, 5);

    // run 3: tx_done withheld, ERROR after 100 cycles in TX_WAIT
    u_bus.math_done = 1'b0;
    u_bus.start = 1'b1; u_bus.target = 12'h222;
    step();
    u_bus.start = 1'b0;
    u_bus.location_valid = 1'b1;
    step();
    u_bus.location_valid = 1'b0;
    step(); step();
    u_bus.math_done = 1'b1; u_bus.math_needed_orientation = 5'd3; u_bus.math_move_command = {5'd3, 7'd50};
    step(); step();
    u_bus.math_done = 1'b0;
    chk("t_tx", u_bus.tx_start, 1);
    snap_done = cnt_done;
    step();
    repeat (99) step();
    chk("t_busy_99", u_bus.busy, 1);
    chk("t_terr_99", u_bus.timeout_err, 0);
    step();
    chk("t_busy", u_bus.busy, 0);
    chk("t_terr", u_bus.timeout_err, 1);
    chk("t_done", u_bus.done, 0);
    step();
    chk("t_terr_hold", u_bus.timeout_err, 1);
    chk("t_done_cnt",  cnt_done - snap_done, 0);

    // restart clears timeout_err
    u_bus.start = 1'b1; u_bus.target = 12'h333;
    step();
    u_bus.start = 1'b0;
    chk("rs_terr", u_bus.timeout_err, 0);
    chk("rs_busy", u_bus.busy, 1);
    chk("rs_tgt",  u_bus.math_target, 12'h333);
    u_bus.location = 12'h0C8; u_bus.location_valid = 1'b1;
    step();
    u_bus.location_valid = 1'b0;
    chk("rs_en", u_bus.math_enable, 1);
    step(); step();
    u_bus.math_done = 1'b1; u_bus.math_needed_orientation = 5'd12; u_bus.math_move_command = {5'd12, 7'd60};
    step(); step();
    u_bus.math_done = 1'b0;
    step();

    // reset during TX_WAIT
    snap_en = cnt_en; snap_tx = cnt_tx; snap_done = cnt_done;
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mr_busy",   u_bus.busy, 0);
    chk("mr_orient", u_bus.current_orientation, 6);
    chk("mr_cmd",    u_bus.tx_command, 0);
    u_bus.tx_done = 1'b1;
    step();
    u_bus.tx_done = 1'b0;
    repeat (5) step();
    chk("mr_orient2", u_bus.current_orientation, 6);
    chk("mr_steps",   u_bus.step_count, 0);
    chk("mr_en_cnt",  cnt_en - snap_en, 0);
    chk("mr_tx_cnt",  cnt_tx - snap_tx, 0);
    chk("mr_dn_cnt",  cnt_done - snap_done, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
